// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and opcode encodings.
package alu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OP_W  = 4;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOR = 4'b1100;

endpackage

// File: rtl/bad_alu_if.sv
// Operand/opcode request and result/zero response bundle for bad_alu.
interface bad_alu_if #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
);
  import alu_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OP_W-1:0]  Opin;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (output A, output B, output Opin, input result, input zero);
  modport slave  (input A, input B, input Opin, output result, output zero);

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU function; undefined opcodes yield zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  logic w_lt;

  assign w_lt = ($signed(i_a) < $signed(i_b));

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_SLT:  o_y = WIDTH'(w_lt);
      OP_NOR:  o_y = ~(i_a | i_b);
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/bad_alu.sv
// Two-stage registered ALU: operand capture stage, then result/zero stage.
module bad_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  bad_alu_if.slave   bus
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [WIDTH-1:0] w_y;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_y)
  );

  // Reset clears both stages so in-flight ops are dropped and outputs read 0/zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_a      <= bus.A;
      r_b      <= bus.B;
      r_op     <= bus.Opin;
      r_result <= w_y;
      r_zero   <= (w_y == '0);
    end
  end

  assign bus.result = r_result;
  assign bus.zero   = r_zero;

endmodule

// File: tb/tb_bad_alu.sv
// Scoreboard bench for bad_alu: driver queues expected results, monitor checks them.
module tb_bad_alu;

  logic clk;
  logic rst_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int          due;
    logic [31:0] res;
  } exp_t;

  exp_t q[$];

  bad_alu_if #(.WIDTH(32)) bus ();

  bad_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned la, lb, m;
    int sa, sb;
    la = 64'(a);
    lb = 64'(b);
    m  = 64'h1_0000_0000;
    sa = a;
    sb = b;
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return 32'((la + lb) % m);
      4'h6:    return 32'((la + m - lb) % m);
      4'h7:    return (sa < sb) ? 32'd1 : 32'd0;
      4'hC:    return 32'hFFFF_FFFF - (a | b);
      default: return 32'h0;
    endcase
  endfunction

  task automatic issue_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e);
    exp_t x;
    bus.Opin = op;
    bus.A    = a;
    bus.B    = b;
    x.due    = cyc + 2;
    x.res    = e;
    q.push_back(x);
    @(posedge clk);
    #20;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue_exp(op, a, b, ref_alu(op, a, b));
  endtask

  // One reset edge: anything in flight is discarded; both stages then read as zero.
  task automatic do_reset();
    exp_t x;
    rst_n    = 1'b0;
    bus.Opin = 4'h0;
    bus.A    = 32'h0;
    bus.B    = 32'h0;
    @(posedge clk);
    #20;
    q.delete();
    x.res = 32'h0;
    x.due = cyc;
    q.push_back(x);
    x.due = cyc + 1;
    q.push_back(x);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rnd_op();
    logic [3:0] ops [6];
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
    if ($urandom_range(0, 9) < 8) return ops[$urandom_range(0, 5)];
    return 4'($urandom);
  endfunction

  // Monitor: output is presented every cycle; compare whenever an expectation is due.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      if (q[0].due == cyc) begin
        e = q.pop_front();
        total++;
        if (bus.result !== e.res || bus.zero !== (e.res == 32'h0)) begin
          bad++;
          $display("FAIL alu_out cyc=%0d got result=%h zero=%b exp result=%h zero=%b",
                   cyc, bus.result, bus.zero, e.res, (e.res == 32'h0));
        end
      end else if (q[0].due < cyc) begin
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_check due=%0d now=%0d exp=%h", e.due, cyc, e.res);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    bus.Opin = 4'h0;
    bus.A    = 32'h0;
    bus.B    = 32'h0;
    @(posedge clk);
    #20;
    do_reset();

    issue_exp(4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    issue_exp(4'h6, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);
    issue_exp(4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    issue_exp(4'h7, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    issue_exp(4'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    issue_exp(4'h1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    issue_exp(4'hC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F);
    issue_exp(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000);
    issue_exp(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      issue(rnd_op(), rnd_operand(), rnd_operand());
    end

    repeat (4) @(posedge clk);
    #20;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
